// File: rtl/ifetch_stage_if.sv
// ifetch_stage_if: redirect, instruction-memory and downstream beat signals of
// the k11 fetch stage. The master modport is the fetch stage itself; the slave
// modport is its environment (memory, redirect source, first pipeline register).
// Optional IFETCH_PERF_EN adds the stall/drop counters.
interface ifetch_stage_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        ready_i;
`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] drop_cnt_o;
`endif

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_i,
        output imem_req_o, imem_addr_o, valid_o, pc_o,
`ifdef IFETCH_PERF_EN
        output inst_o, stall_cnt_o, drop_cnt_o
`else
        output inst_o
`endif
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_i,
        input  imem_req_o, imem_addr_o, valid_o, pc_o,
`ifdef IFETCH_PERF_EN
        input  inst_o, stall_cnt_o, drop_cnt_o
`else
        input  inst_o
`endif
    );
endinterface

// File: rtl/ifetch_stage.sv
// ifetch_stage: k11 instruction fetch front end. Issues sequential word
// requests under a credit limit of DEPTH (in-flight + buffered), collects
// in-order responses into a DEPTH-entry FIFO, and on redirect flushes the FIFO
// and drops responses still in flight.
// Optional feature macro: IFETCH_PERF_EN (stall_cnt_o / drop_cnt_o counters).
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic           clk,
    input logic           rst,
    ifetch_stage_if.master bus
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, rsp_pc_q;
    logic [CW-1:0] outstanding_q, discard_q, count_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];

    logic [CW:0]   credits_used;
    logic          grant, push, pop, drop, not_empty;
    logic [31:0]   redirect_pc;

    // Credits count both in-flight requests and buffered beats, so a response
    // always finds a free FIFO slot; discarded responses release theirs too.
    assign credits_used = {1'b0, outstanding_q} + {1'b0, count_q};
    assign redirect_pc  = bus.redirect_pc_i & ~32'h3;
    assign not_empty    = (count_q != '0);

    assign bus.imem_req_o  = ~rst & ~bus.redirect_i & (credits_used < DEPTH_W);
    assign bus.imem_addr_o = pc_q;
    assign bus.valid_o     = not_empty & ~bus.redirect_i;
    assign bus.pc_o        = not_empty ? fifo_pc[rd_ptr_q]   : 32'h0;
    assign bus.inst_o      = not_empty ? fifo_inst[rd_ptr_q] : 32'h0;

    assign grant = bus.imem_req_o & bus.imem_gnt_i;
    assign pop   = bus.valid_o & bus.ready_i;
    assign drop  = bus.imem_rvalid_i & (discard_q != '0);
    assign push  = bus.imem_rvalid_i & ~bus.redirect_i & (discard_q == '0);

    // Fetch/response PCs, credit and discard bookkeeping, FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else if (bus.redirect_i) begin
            // A response landing this cycle is already gone, so it is not
            // discarded again; older pending discards are folded in here.
            pc_q          <= redirect_pc;
            rsp_pc_q      <= redirect_pc;
            outstanding_q <= outstanding_q - CW'(bus.imem_rvalid_i);
            discard_q     <= outstanding_q - CW'(bus.imem_rvalid_i);
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            if (grant) pc_q <= pc_q + 32'd4;
            outstanding_q <= outstanding_q + CW'(grant) - CW'(bus.imem_rvalid_i);
            if (drop) discard_q <= discard_q - 1'b1;
            if (push) begin
                rsp_pc_q <= rsp_pc_q + 32'd4;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are don't-care while the slot is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]   <= rsp_pc_q;
            fifo_inst[wr_ptr_q] <= bus.imem_rdata_i;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cnt_q, drop_cnt_q;

    // Starvation and dropped-response counters, both free-running and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (!not_empty && !bus.redirect_i) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.imem_rvalid_i && (bus.redirect_i || discard_q != '0))
                drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.drop_cnt_o  = drop_cnt_q;
`else
    // Performance counters not built.
`endif

`ifndef SYNTHESIS
    // A response with nothing in flight means memory and fetch disagree.
    rvalid_has_credit: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rvalid_i |-> (outstanding_q != '0));
`endif
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed scenarios plus a randomized run of ifetch_stage
// against an in-order memory model and a stream-level model: after reset or a
// redirect to T, granted addresses and delivered beats must be T, T+4, ...
module tb_ifetch_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_stage_if bus ();
    ifetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, errors = 0, cyc = 0;
    int lat = 1, gnt_pct = 100, last_due = 0;
    logic ready_v = 1'b1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] obs_req[$], obs_pc[$], obs_inst[$];
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    // One clock: drive memory/ready, sample mid-cycle, record grants and beats.
    task automatic step();
        bus.imem_gnt_i = ($urandom_range(99) < gnt_pct);
        bus.ready_i    = ready_v;
        if (rst) begin
            mq_addr.delete(); mq_due.delete(); last_due = cyc;
        end
        if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
        end
        @(negedge clk);
        s_req = bus.imem_req_o; s_addr = bus.imem_addr_o;
        s_valid = bus.valid_o; s_pc = bus.pc_o; s_inst = bus.inst_o;
        if (s_req && bus.imem_gnt_i) begin
            int d;
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq_addr.push_back(s_addr); mq_due.push_back(d); obs_req.push_back(s_addr);
        end
        if (s_valid && bus.ready_i) begin
            obs_pc.push_back(s_pc); obs_inst.push_back(s_inst);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic clear_obs();
        obs_req.delete(); obs_pc.delete(); obs_inst.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.redirect_i = 1'b0;
        step(); step();
        rst = 1'b0; lat = 1; gnt_pct = 100; ready_v = 1'b1;
        clear_obs();
    endtask

    task automatic redirect_to(input logic [31:0] t);
        bus.redirect_i = 1'b1; bus.redirect_pc_i = t;
        step();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL redir_req_low got %b exp 0", s_req); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_low got %b exp 0", s_valid); end
        bus.redirect_i = 1'b0; bus.redirect_pc_i = $urandom;
        clear_obs();
    endtask

    task automatic test_reset();
        rst = 1'b1; ready_v = 1'b1;
        step(); step();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", s_req); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", s_valid); end
        checks++; if (s_pc !== 32'h0 || s_inst !== 32'h0) begin errors++; $display("FAIL rst_pc_inst got %h/%h exp 0/0", s_pc, s_inst); end
`ifdef IFETCH_PERF_EN
        checks++; if (bus.stall_cnt_o !== 32'h0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", bus.stall_cnt_o); end
`endif
        rst = 1'b0; clear_obs();
        step();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL first_req got %b@%h exp 1@0", s_req, s_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        repeat (20) step();
        checks++; if (obs_req.size() < 8 || obs_pc.size() < 6) begin errors++; $display("FAIL stream_count got %0d/%0d exp >=8/>=6", obs_req.size(), obs_pc.size()); end
        for (int i = 0; i < obs_req.size() && i < 8; i++) begin
            checks++; if (obs_req[i] !== 32'(4*i)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, obs_req[i], 32'(4*i)); end
        end
        for (int i = 0; i < obs_pc.size() && i < 6; i++) begin
            checks++;
            if (obs_pc[i] !== 32'(4*i) || obs_inst[i] !== mem_word(32'(4*i))) begin
                errors++; $display("FAIL stream_beat[%0d] got %h/%h exp %h/%h", i, obs_pc[i], obs_inst[i], 32'(4*i), mem_word(32'(4*i)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        ready_v = 1'b0;
        repeat (10) step();
        checks++; if (obs_req.size() != 2) begin errors++; $display("FAIL stall_req_count got %0d exp 2", obs_req.size()); end
        checks++; if (obs_req.size() >= 2 && (obs_req[0] !== 32'h0 || obs_req[1] !== 32'h4)) begin errors++; $display("FAIL stall_req_addr got %h,%h exp 0,4", obs_req[0], obs_req[1]); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_req_low got %b exp 0", s_req); end
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_inst !== mem_word(32'h0)) begin errors++; $display("FAIL stall_head got %b %h/%h exp 1 0/%h", s_valid, s_pc, s_inst, mem_word(32'h0)); end
        ready_v = 1'b1;
        repeat (12) step();
        checks++;
        if (obs_pc.size() < 3) begin errors++; $display("FAIL stall_drain_count got %0d exp >=3", obs_pc.size()); end
        else if (obs_pc[0] !== 32'h0 || obs_pc[1] !== 32'h4 || obs_pc[2] !== 32'h8) begin
            errors++; $display("FAIL stall_drain_order got %h,%h,%h exp 0,4,8", obs_pc[0], obs_pc[1], obs_pc[2]);
        end
        checks++; if (obs_req.size() < 3 || obs_req[2] !== 32'h8) begin errors++; $display("FAIL stall_resume got %h exp 8", obs_req.size() < 3 ? 32'hX : obs_req[2]); end
    endtask

    // Beats and grants after a redirect must run sequentially from t.
    task automatic check_from(input string tag, input logic [31:0] t, input int min_beats);
        checks++; if (obs_pc.size() < min_beats) begin errors++; $display("FAIL %s_beats got %0d exp >=%0d", tag, obs_pc.size(), min_beats); end
        for (int i = 0; i < obs_req.size(); i++) begin
            checks++; if (obs_req[i] !== t + 32'(4*i)) begin errors++; $display("FAIL %s_addr[%0d] got %h exp %h", tag, i, obs_req[i], t + 32'(4*i)); end
        end
        for (int i = 0; i < obs_pc.size(); i++) begin
            checks++;
            if (obs_pc[i] !== t + 32'(4*i) || obs_inst[i] !== mem_word(t + 32'(4*i))) begin
                errors++; $display("FAIL %s_beat[%0d] got %h/%h exp %h/%h", tag, i, obs_pc[i], obs_inst[i], t + 32'(4*i), mem_word(t + 32'(4*i)));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        lat = 3;
        step(); step();
        checks++; if (obs_req.size() != 2 || obs_pc.size() != 0) begin errors++; $display("FAIL inflight_setup got %0d req %0d beats exp 2/0", obs_req.size(), obs_pc.size()); end
        redirect_to(32'h0000_0103);
        repeat (20) step();
        check_from("redir_lat3", 32'h100, 3);
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        lat = 2;
        step(); step();
        redirect_to(32'h0000_0200);
        repeat (20) step();
        check_from("redir_rvalid", 32'h200, 3);
    endtask

    task automatic test_redirect_ungranted();
        logic [31:0] a0;
        do_reset();
        gnt_pct = 0;
        step();
        a0 = s_addr;
        checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL hold_req got %b exp 1", s_req); end
        step(); step();
        checks++; if (s_req !== 1'b1 || s_addr !== a0) begin errors++; $display("FAIL hold_stable got %b@%h exp 1@%h", s_req, s_addr, a0); end
        redirect_to(32'h0000_0300);
        gnt_pct = 100;
        repeat (15) step();
        check_from("redir_ungnt", 32'h300, 3);
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_to(32'hFFFF_FFFE);
        repeat (12) step();
        check_from("wrap", 32'hFFFF_FFFC, 3);
        checks++; if (obs_req.size() < 2 || obs_req[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", obs_req.size() < 2 ? 32'hX : obs_req[1]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_v = 1'b0;
        repeat (8) step();
        checks++; if (s_valid !== 1'b1 || s_req !== 1'b0) begin errors++; $display("FAIL full_setup got valid %b req %b exp 1/0", s_valid, s_req); end
        rst = 1'b1; ready_v = 1'b1;
        step(); step();
        checks++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin errors++; $display("FAIL midrst_out got valid %b req %b exp 0/0", s_valid, s_req); end
`ifdef IFETCH_PERF_EN
        checks++; if (bus.stall_cnt_o !== 32'h0) begin errors++; $display("FAIL midrst_stall_cnt got %0d exp 0", bus.stall_cnt_o); end
`endif
        rst = 1'b0; clear_obs();
        step();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL midrst_req got %b@%h exp 1@0", s_req, s_addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_req, exp_pc, tgt;
        int beats;
        do_reset();
        exp_req = 32'h0; exp_pc = 32'h0; beats = 0;
        for (int n = 0; n < 600; n++) begin
            gnt_pct = 30 + $urandom_range(70);
            lat     = $urandom_range(1, 4);
            ready_v = ($urandom_range(9) < 7);
            if ($urandom_range(99) < 5) begin
                tgt = $urandom;
                redirect_to(tgt);
                exp_req = tgt & ~32'h3; exp_pc = tgt & ~32'h3;
            end else begin
                step();
            end
            while (obs_req.size() > 0) begin
                logic [31:0] a;
                a = obs_req.pop_front();
                checks++; if (a !== exp_req) begin errors++; $display("FAIL rand_addr got %h exp %h", a, exp_req); end
                exp_req = exp_req + 32'd4;
            end
            while (obs_pc.size() > 0) begin
                logic [31:0] p, d;
                p = obs_pc.pop_front(); d = obs_inst.pop_front();
                checks++;
                if (p !== exp_pc || d !== mem_word(exp_pc)) begin errors++; $display("FAIL rand_beat got %h/%h exp %h/%h", p, d, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4; beats++;
            end
        end
        checks++; if (beats < 50) begin errors++; $display("FAIL rand_progress got %0d beats exp >=50", beats); end
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;
        bus.ready_i = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_rvalid();
        test_redirect_ungranted();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
